seg_scan_reg: RTL and testbench

Parametrised successor to the 8-position 7-segment digit register. It stores NUM_DIGITS hex digits, each with decimal-point and blank flags, through a write port. A registered read port returns the decoded segment pattern of any position. An autonomous scan engine time-multiplexes all digits onto a shared segment bus with a one-hot digit select, for direct drive of a multiplexed display.

---
 rtl/seg_scan_reg.sv | 193 +++++++++++++++++++
 tb/tb_seg_scan_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_reg.sv
// seg_scan_reg: multiplexed 7-segment display register.
//
// Holds NUM_DIGITS hex digits. Each digit has a decimal-point flag and a
// blank flag. A registered read port returns the decoded pattern of any
// position. A free-running scan engine drives one digit at a time onto a
// shared segment bus, with a one-hot digit select.
//
// Ports:
//   clk       rising-edge system clock
//   rst_n     synchronous active-low reset
//   wr_en     write strobe; a write to wr_pos >= NUM_DIGITS is dropped
//   wr_pos    target position
//   wr_data   hex value
//   wr_dp     decimal-point flag
//   wr_blank  1 = position shows nothing
//   wr_blink  blink-enable flag (only present with SEG_BLINK_EN)
//   rd_pos    read position
//   rd_seg    {dp,g,f,e,d,c,b,a} of rd_pos, active-high, 1-cycle latency
//   seg       scanned segment bus; inverted when SEG_ACTIVE_LOW
//   dig_sel   one-hot digit enable; inverted when SEG_ACTIVE_LOW
//   scan_tick one-cycle pulse when the scan index advances
//
// Optional feature (macro SEG_BLINK_EN): per-digit blink. A phase bit toggles
// every BLINK_FRAMES complete frames. While the phase bit is 1, blinking
// digits drive all segments off. Without the macro, the display behaves as
// if the phase bit is always 0.
module seg_scan_reg #(
  parameter int NUM_DIGITS     = 8,
  parameter int PRESCALE       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int BLINK_FRAMES   = 64,
  localparam int POS_W         = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [POS_W-1:0]      wr_pos,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  wr_blank,
`ifdef SEG_BLINK_EN
  input  logic                  wr_blink,
`endif
  input  logic [POS_W-1:0]      rd_pos,
  output logic [7:0]            rd_seg,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  scan_tick
);

  localparam int                  PS_W    = $clog2(PRESCALE);
  localparam logic [POS_W:0]      ND      = (POS_W+1)'(NUM_DIGITS);
  localparam logic [POS_W-1:0]    LAST    = POS_W'(NUM_DIGITS - 1);
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  // The "off" level of each pin bus. XOR with it applies the pin polarity.
  localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEG_ACTIVE_LOW ? '1 : '0;

  if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("seg_scan_reg: NUM_DIGITS must be 2..16");
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("seg_scan_reg: PRESCALE must be >= 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("seg_scan_reg: BLINK_FRAMES must be >= 1");
  end

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] pattern(input logic [3:0] v, input logic dp, input logic bl);
    pattern = bl ? 8'h00 : {dp, decode(v)};
  endfunction

  logic [3:0]            val_q   [NUM_DIGITS];
  logic                  dp_q    [NUM_DIGITS];
  logic                  blank_q [NUM_DIGITS];
  logic [PS_W-1:0]       cnt_q;
  logic [POS_W-1:0]      idx_q;
  logic                  step;
  logic [7:0]            rd_pat;
  logic [7:0]            disp_pat;
  logic [NUM_DIGITS-1:0] sel_oh;
  logic [7:0]            rd_seg_p1;
  logic [7:0]            seg_p1;
  logic [NUM_DIGITS-1:0] dig_sel_p1;
  logic                  scan_tick_p1;

  assign step = (cnt_q == PS_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        val_q[i]   <= 4'h0;
        dp_q[i]    <= 1'b0;
        blank_q[i] <= 1'b1;
      end
    end else if (wr_en && ({1'b0, wr_pos} < ND)) begin
      val_q[wr_pos]   <= wr_data;
      dp_q[wr_pos]    <= wr_dp;
      blank_q[wr_pos] <= wr_blank;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      scan_tick_p1 <= 1'b0;
    end else begin
      scan_tick_p1 <= step;
      if (step) begin
        cnt_q <= '0;
        idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int              BF_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic            blink_q [NUM_DIGITS];
  logic [BF_W-1:0] frame_q;
  logic            phase_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) blink_q[i] <= 1'b0;
    end else if (wr_en && ({1'b0, wr_pos} < ND)) begin
      blink_q[wr_pos] <= wr_blink;
    end
  end

  // A frame completes when the index wraps from the last digit back to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if (step && (idx_q == LAST)) begin
      if (frame_q == BF_LAST) begin
        frame_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        frame_q <= frame_q + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    rd_pat = 8'h00;
    if ({1'b0, rd_pos} < ND) rd_pat = pattern(val_q[rd_pos], dp_q[rd_pos], blank_q[rd_pos]);
    disp_pat = pattern(val_q[idx_q], dp_q[idx_q], blank_q[idx_q]);
`ifdef SEG_BLINK_EN
    if (phase_q && blink_q[idx_q]) disp_pat = 8'h00;
`endif
    sel_oh        = '0;
    sel_oh[idx_q] = 1'b1;
  end

  // Stage p1: output registers. Storage is read before this edge's write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_seg_p1  <= 8'h00;
      seg_p1     <= SEG_OFF;
      dig_sel_p1 <= SEL_OFF;
    end else begin
      rd_seg_p1  <= rd_pat;
      seg_p1     <= disp_pat ^ SEG_OFF;
      dig_sel_p1 <= sel_oh ^ SEL_OFF;
    end
  end

  assign rd_seg    = rd_seg_p1;
  assign seg       = seg_p1;
  assign dig_sel   = dig_sel_p1;
  assign scan_tick = scan_tick_p1;

endmodule

// File: tb/tb_seg_scan_reg.sv
// Bench for seg_scan_reg. Two instances share one set of input stimulus:
//   a: 6 digits, active-high pins (exercises out-of-range positions)
//   b: 8 digits, active-low pins
// Both use PRESCALE=4. Read and scan expectations go into queues. A monitor
// pops them when the DUT output is due and compares.
module tb_seg_scan_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_pos = '0;
  logic [3:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic       wr_blank = 1'b0;
  logic [2:0] rd_pos = '0;
  logic       rd_req = 1'b0;

  logic [7:0] a_rd, a_seg, b_rd, b_seg, b_sel;
  logic [5:0] a_sel;
  logic       a_tick, b_tick;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [5:0] sa;
    logic [7:0] ga;
    logic [7:0] sb;
    logic [7:0] gb;
  } scan_exp_t;

  logic [15:0] rd_q[$];
  scan_exp_t   scan_q[$];

  always #5 clk = ~clk;

  seg_scan_reg #(.NUM_DIGITS(6), .PRESCALE(4), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_pos(wr_pos), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_blank(wr_blank),
`ifdef SEG_BLINK_EN
    .wr_blink(1'b0),
`endif
    .rd_pos(rd_pos), .rd_seg(a_rd), .seg(a_seg), .dig_sel(a_sel), .scan_tick(a_tick)
  );

  seg_scan_reg #(.NUM_DIGITS(8), .PRESCALE(4), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_pos(wr_pos), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_blank(wr_blank),
`ifdef SEG_BLINK_EN
    .wr_blink(1'b0),
`endif
    .rd_pos(rd_pos), .rd_seg(b_rd), .seg(b_seg), .dig_sel(b_sel), .scan_tick(b_tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge; queue the read expectation.
  task automatic step(input logic we, input logic [2:0] wp, input logic [3:0] wd,
                      input logic wdp, input logic wbl, input logic re,
                      input logic [2:0] rp, input logic [7:0] ea, input logic [7:0] eb);
    @(negedge clk);
    wr_en = we; wr_pos = wp; wr_data = wd; wr_dp = wdp; wr_blank = wbl;
    rd_req = re; rd_pos = rp;
    if (re) rd_q.push_back({ea, eb});
  endtask

  // Monitor: rd_seg is due one edge after a read request. The scan buses are
  // due one edge after scan_tick. scan_tick must recur every 4 cycles,
  // counted from the last reset edge.
  int   cyc = 0;
  int   last_evt = 0;
  logic tick_prev = 1'b0;
  logic mon_rs, mon_rq;
  logic [15:0] rexp;
  scan_exp_t   sexp;

  always @(posedge clk) begin
    mon_rs = rst_n;
    mon_rq = rd_req;
    #1;
    cyc++;
    if (!mon_rs) begin
      last_evt  = cyc;
      tick_prev = 1'b0;
    end else begin
      if (tick_prev && scan_q.size() > 0) begin
        sexp = scan_q.pop_front();
        chk("scan_a_dig_sel", a_sel, sexp.sa);
        chk("scan_a_seg", a_seg, sexp.ga);
        chk("scan_b_dig_sel", b_sel, sexp.sb);
        chk("scan_b_seg", b_seg, sexp.gb);
      end
      if (a_tick || b_tick) begin
        chk("tick_a_eq_b", b_tick, a_tick);
        chk("tick_period", cyc - last_evt, 4);
        last_evt = cyc;
      end
      tick_prev = a_tick;
    end
    if (mon_rq) begin
      if (rd_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL rd_queue: got empty expected entry");
      end else begin
        rexp = rd_q.pop_front();
        chk("rd_seg_a", a_rd, rexp[15:8]);
        chk("rd_seg_b", b_rd, rexp[7:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  logic [7:0] exp_a [8] = '{8'h3F, 8'h86, 8'h5B, 8'hCF, 8'h66, 8'hED, 8'h00, 8'h00};
  logic [7:0] exp_b [8] = '{8'h3F, 8'h86, 8'h5B, 8'hCF, 8'h66, 8'hED, 8'h7D, 8'h87};
  int w;

  initial begin
    // Reset held for 3 edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_rd_seg", a_rd, 8'h00);
    chk("rst_b_rd_seg", b_rd, 8'h00);
    chk("rst_a_tick", a_tick, 1'b0);
    chk("rst_a_seg", a_seg, 8'h00);
    chk("rst_a_dig_sel", a_sel, 6'h00);
    chk("rst_b_seg", b_seg, 8'hFF);
    chk("rst_b_dig_sel", b_sel, 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    // Digit 0 is selected but blank after reset.
    chk("rel_a_dig_sel", a_sel, 6'h01);
    chk("rel_a_seg", a_seg, 8'h00);
    chk("rel_b_dig_sel", b_sel, 8'hFE);
    chk("rel_b_seg", b_seg, 8'hFF);

    // Write value=pos, dp on odd positions; a drops positions 6 and 7.
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 4'(i), i[0], 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 3'(i), exp_a[i], exp_b[i]);

    // Out-of-range write of F to position 7 on a; in range on b.
    step(1'b1, 3'd7, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd7, 8'h00, 8'h71);
    step(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5, 8'hED, 8'hED);

    // Same-cycle write and read of position 3: old pattern first, then new.
    step(1'b1, 3'd3, 4'h8, 1'b0, 1'b0, 1'b1, 3'd3, 8'hCF, 8'hCF);
    step(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h7F, 8'h7F);

    // A blank position reads 0 even with a nonzero value stored.
    step(1'b1, 3'd2, 4'h2, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    step(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 8'h00);
    step(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);

    // Mid-scan reset while a shows digit 5.
    w = 0;
    while (a_sel !== 6'h20 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("reach_idx5", a_sel, 6'h20);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_a_dig_sel", a_sel, 6'h00);
    chk("mid_rst_a_seg", a_seg, 8'h00);
    chk("mid_rst_a_tick", a_tick, 1'b0);
    chk("mid_rst_b_dig_sel", b_sel, 8'hFF);
    rst_n = 1'b1;
    wr_en = 1'b1; wr_pos = 3'd0; wr_data = 4'hA; wr_dp = 1'b0; wr_blank = 1'b0;
    step(1'b1, 3'd1, 4'hB, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step(1'b1, 3'd2, 4'h5, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    step(1'b1, 3'd3, 4'h4, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step(1'b1, 3'd4, 4'hE, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step(1'b1, 3'd5, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);

    // Scan steps 2..8 after the reset: a shows index k mod 6, b shows k mod 8.
    scan_q.push_back('{6'h04, 8'h00, 8'hFB, 8'hFF});
    scan_q.push_back('{6'h08, 8'hE6, 8'hF7, 8'h19});
    scan_q.push_back('{6'h10, 8'h79, 8'hEF, 8'h86});
    scan_q.push_back('{6'h20, 8'hF1, 8'hDF, 8'h0E});
    scan_q.push_back('{6'h01, 8'h77, 8'hBF, 8'hFF});
    scan_q.push_back('{6'h02, 8'h7C, 8'h7F, 8'hFF});
    scan_q.push_back('{6'h04, 8'h00, 8'hFE, 8'h88});

    w = 0;
    while (scan_q.size() > 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (scan_q.size() > 0) begin
      n_chk++; n_err++;
      $display("FAIL scan_drain: got %0d pending expected 0", scan_q.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
